// File: rtl/dcache_pkg.sv
// Shared widths, tag-entry bit positions and controller state encodings
// for the direct-mapped D-cache controller.
package dcache_pkg;

  localparam int TAG_W       = 22;
  localparam int INDEX_W     = 5;
  localparam int WORD_OFF_W  = 3;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 256;
  localparam int ENTRY_W     = 24;
  localparam int VALID_BIT   = 23;
  localparam int DIRTY_BIT   = 22;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT       = 3'd0;
  localparam state_t ST_IDLE       = 3'd1;
  localparam state_t ST_WRITEBACK  = 3'd2;
  localparam state_t ST_REFILL     = 3'd3;
  localparam state_t ST_REFILLDONE = 3'd4;

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational word select / word insert on a 256-bit cache line.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]     line_i,
  input  logic [WORD_W-1:0]     word_i,
  input  logic [WORD_OFF_W-1:0] off_i,
  output logic [WORD_W-1:0]     word_o,
  output logic [LINE_W-1:0]     line_o
);

  logic [7:0] bit_base;

  assign bit_base = {off_i, 5'd0};

  always_comb begin
    word_o = line_i[bit_base +: WORD_W];
    line_o = line_i;
    line_o[bit_base +: WORD_W] = word_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// D-cache controller: tag/data SRAM master, write-back + refill on miss.
// Optional hit/miss counters are compiled in with DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         p1_addr_i,
  input  logic [31:0]         p1_data_i,
  input  logic                p1_MemRead_i,
  input  logic                p1_MemWrite_i,
  output logic [31:0]         p1_data_o,
  output logic                p1_stall_o,
  output logic [INDEX_W-1:0]  tag_addr_o,
  output logic [ENTRY_W-1:0]  tag_data_o,
  output logic                tag_enable_o,
  output logic                tag_write_o,
  input  logic [ENTRY_W-1:0]  tag_data_i,
  output logic [INDEX_W-1:0]  data_addr_o,
  output logic [LINE_W-1:0]   data_data_o,
  output logic                data_enable_o,
  output logic                data_write_o,
  input  logic [LINE_W-1:0]   data_data_i,
  output logic [31:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  input  logic [LINE_W-1:0]   mem_data_i,
  input  logic                mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);

  // CPU handshake: a request (MemRead|MemWrite) is accepted in the cycle
  // where p1_stall_o=0; while stall is high the CPU holds the request.
  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [WORD_OFF_W-1:0] req_word;
  logic                  req, is_store, hit, victim_dirty;
  logic [WORD_W-1:0]     rd_word;
  logic [LINE_W-1:0]     merged_line;
  logic                  unused_addr_lsb;

  assign req_tag         = p1_addr_i[31:10];
  assign req_idx         = p1_addr_i[9:5];
  assign req_word        = p1_addr_i[4:2];
  assign unused_addr_lsb = ^p1_addr_i[1:0];
  assign req             = p1_MemRead_i | p1_MemWrite_i;
  assign is_store        = p1_MemWrite_i;
  assign hit             = tag_data_i[VALID_BIT] && (tag_data_i[TAG_W-1:0] == req_tag);
  assign victim_dirty    = tag_data_i[VALID_BIT] && tag_data_i[DIRTY_BIT];

  dcache_word_merge u_merge (
    .line_i (data_data_i),
    .word_i (p1_data_i),
    .off_i  (req_word),
    .word_o (rd_word),
    .line_o (merged_line)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p1_data_o     = '0;
    p1_stall_o    = 1'b0;
    tag_addr_o    = req_idx;
    tag_data_o    = '0;
    tag_enable_o  = 1'b0;
    tag_write_o   = 1'b0;
    data_addr_o   = req_idx;
    data_data_o   = '0;
    data_enable_o = 1'b0;
    data_write_o  = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    case (state_q)
      ST_INIT: begin
        p1_stall_o   = 1'b1;
        tag_addr_o   = cnt_q;
        tag_enable_o = 1'b1;
        tag_write_o  = 1'b1;
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          tag_enable_o  = 1'b1;
          data_enable_o = 1'b1;
          if (hit) begin
            if (is_store) begin
              data_write_o = 1'b1;
              data_data_o  = merged_line;
              tag_write_o  = 1'b1;
              tag_data_o   = {1'b1, 1'b1, req_tag};
            end else begin
              p1_data_o = rd_word;
            end
          end else begin
            p1_stall_o = 1'b1;
            state_d    = victim_dirty ? ST_WRITEBACK : ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        // Victim tag and line are read live from the SRAMs; neither is
        // written until the refill ack, so they stay stable here.
        p1_stall_o    = 1'b1;
        tag_enable_o  = 1'b1;
        data_enable_o = 1'b1;
        mem_enable_o  = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = {tag_data_i[TAG_W-1:0], req_idx, 5'd0};
        mem_data_o    = data_data_i;
        if (mem_ack_i) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, 5'd0};
        if (mem_ack_i) begin
          tag_enable_o  = 1'b1;
          tag_write_o   = 1'b1;
          tag_data_o    = {1'b1, 1'b0, req_tag};
          data_enable_o = 1'b1;
          data_write_o  = 1'b1;
          data_data_o   = mem_data_i;
          state_d       = ST_REFILLDONE;
        end
      end
      ST_REFILLDONE: begin
        p1_stall_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DCACHE_STATS_EN
  // replay_q marks the IDLE cycle right after a refill so its hit is not counted.
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        replay_q, replay_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    replay_d   = (state_q == ST_REFILLDONE);
    if ((state_q == ST_IDLE) && req && !replay_q) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      replay_q   <= replay_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with tag/data SRAM and memory models.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
  logic [4:0]   tag_addr_o, data_addr_o;
  logic [23:0]  tag_data_o, tag_data_i;
  logic         tag_enable_o, tag_write_o, data_enable_o, data_write_o;
  logic [255:0] data_data_o, data_data_i, mem_data_o, mem_data_i;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int mem_cyc = 0;
  int req_cnt = 0;
  int wb_lat = 1;
  int rf_lat = 1;

  logic [31:0]  rd_exp_q[$];
  logic [31:0]  stall_exp_q[$];
  logic [32:0]  mem_exp_q[$];
  logic [255:0] wb_exp_q[$];

  logic [23:0]  tag_mem[32];
  logic [255:0] data_mem[32];

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o),
    .tag_enable_o(tag_enable_o), .tag_write_o(tag_write_o), .tag_data_i(tag_data_i),
    .data_addr_o(data_addr_o), .data_data_o(data_data_o),
    .data_enable_o(data_enable_o), .data_write_o(data_write_o), .data_data_i(data_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- models ----------------
  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'd0};
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hA500_0000 | (base + 32'(w * 4));
    return l;
  endfunction

  assign tag_data_i  = tag_mem[tag_addr_o];
  assign data_data_i = data_mem[data_addr_o];
  assign mem_data_i  = line_pat(mem_addr_o);
  assign mem_ack_i   = mem_enable_o && (req_cnt == ((mem_write_o ? wb_lat : rf_lat) - 1));

  always @(posedge clk) begin
    if (tag_enable_o && tag_write_o) tag_mem[tag_addr_o] <= tag_data_o;
    if (data_enable_o && data_write_o) data_mem[data_addr_o] <= data_data_o;
    if (!mem_enable_o || mem_ack_i) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_i) begin
      if (mem_enable_o) mem_cyc++;
      if (p1_MemRead_i || p1_MemWrite_i) begin
        if (p1_stall_o) stall_cnt++;
        else begin
          if (stall_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_resp: response with no expectation queued");
          end else chk("stall_cycles", 256'(stall_cnt), 256'(stall_exp_q.pop_front()));
          if (p1_MemRead_i && !p1_MemWrite_i) begin
            if (rd_exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL load_data: load with no expectation queued");
            end else chk("load_data", 256'(p1_data_o), 256'(rd_exp_q.pop_front()));
          end
          stall_cnt = 0;
        end
      end else stall_cnt = 0;
      if (mem_enable_o && mem_ack_i) begin
        if (mem_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: unexpected memory transfer at %0h", mem_addr_o);
        end else chk("mem_req", 256'({mem_write_o, mem_addr_o}), 256'(mem_exp_q.pop_front()));
        if (mem_write_o) begin
          if (wb_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_data: unexpected writeback");
          end else chk("wb_data", mem_data_o, wb_exp_q.pop_front());
        end
      end
    end else stall_cnt = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_req(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                         input logic wr, input int exp_stall, input logic [31:0] exp_rd);
    stall_exp_q.push_back(32'(exp_stall));
    if (rd && !wr) rd_exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk);
      if (!p1_stall_o) break;
      if (n == 200) begin
        checks++; errors++;
        $display("FAIL req_timeout: stall still %0b after 200 cycles at %0h", p1_stall_o, addr);
      end
    end
    @(posedge clk); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic init_check();
    for (int i = 0; i < 32; i++) begin
      chk("init_sweep", 256'({p1_stall_o, tag_enable_o, tag_write_o, tag_addr_o, tag_data_o}),
          256'({3'b111, 5'(i), 24'h0}));
      @(negedge clk);
    end
    chk("init_done_stall", 256'(p1_stall_o), 256'(0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [255:0] wb_line;
    int m;
    rst_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    #3;
    chk("rst_stall", 256'(p1_stall_o), 256'(1));
    chk("rst_tag_sweep", 256'({tag_enable_o, tag_write_o, tag_addr_o, tag_data_o}), 256'({2'b11, 29'h0}));
    chk("rst_mem", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'(0));
    chk("rst_data", 256'({data_enable_o, data_write_o, p1_data_o}), 256'(0));
`ifdef DCACHE_STATS_EN
    chk("rst_stats", 256'({hit_cnt_o, miss_cnt_o}), 256'(0));
`endif
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    init_check();

    // cold miss, k=4
    rf_lat = 4;
    mem_exp_q.push_back({1'b0, 32'h0000_0400});
    cpu_req(32'h0000_0400, 32'h0, 1'b1, 1'b0, 6, 32'hA500_0400);
    chk("tag0_after_refill", 256'(tag_mem[0]), 256'(24'h800001));

    m = mem_cyc;
    cpu_req(32'h0000_0404, 32'h0, 1'b1, 1'b0, 0, 32'hA500_0404);
    chk("load_hit_no_mem", 256'(mem_cyc), 256'(m));

    m = mem_cyc;
    cpu_req(32'h0000_0408, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 32'h0);
    chk("tag0_dirty", 256'(tag_mem[0]), 256'(24'hC00001));
    chk("store_word2", 256'(data_mem[0][95:64]), 256'(32'hDEAD_BEEF));
    chk("store_hit_no_mem", 256'(mem_cyc), 256'(m));

    // dirty miss, j=3 k=3
    wb_lat = 3; rf_lat = 3;
    wb_line = line_pat(32'h0000_0400);
    wb_line[95:64] = 32'hDEAD_BEEF;
    mem_exp_q.push_back({1'b1, 32'h0000_0400});
    wb_exp_q.push_back(wb_line);
    mem_exp_q.push_back({1'b0, 32'h0000_0800});
    cpu_req(32'h0000_0808, 32'h0, 1'b1, 1'b0, 8, 32'hA500_0808);
    chk("tag0_after_wb", 256'(tag_mem[0]), 256'(24'h800002));
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_plan", 256'(hit_cnt_o), 256'(2));
    chk("miss_cnt_plan", 256'(miss_cnt_o), 256'(2));
`endif

    // store miss on index 1, k=1
    rf_lat = 1;
    mem_exp_q.push_back({1'b0, 32'h0000_0C20});
    cpu_req(32'h0000_0C20, 32'h1234_5678, 1'b0, 1'b1, 3, 32'h0);
    chk("tag1_store_miss", 256'(tag_mem[1]), 256'(24'hC00003));
    // both request lines high acts as a store
    cpu_req(32'h0000_0C24, 32'hCAFE_F00D, 1'b1, 1'b1, 0, 32'h0);
    chk("both_lines_store", 256'(data_mem[1][63:32]), 256'(32'hCAFE_F00D));
    cpu_req(32'h0000_0C20, 32'h0, 1'b1, 1'b0, 0, 32'h1234_5678);
    cpu_req(32'h0000_0C3C, 32'h0, 1'b1, 1'b0, 0, 32'hA500_0C3C);
    cpu_req(32'h0000_0C26, 32'h0, 1'b1, 1'b0, 0, 32'hCAFE_F00D);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_final", 256'(hit_cnt_o), 256'(6));
    chk("miss_cnt_final", 256'(miss_cnt_o), 256'(3));
`endif

    // asynchronous reset in the middle of a refill
    rf_lat = 20;
    @(posedge clk); #1;
    p1_addr_i = 32'h0000_1000; p1_MemRead_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_refill_active", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'({2'b10, 32'h0000_1000}));
    #2 rst_i = 1'b0;
    #1;
    chk("abort_mem_enable", 256'(mem_enable_o), 256'(0));
    chk("abort_init_state", 256'({p1_stall_o, tag_enable_o, tag_write_o, tag_addr_o}), 256'({3'b111, 5'd0}));
`ifdef DCACHE_STATS_EN
    chk("abort_stats", 256'({hit_cnt_o, miss_cnt_o}), 256'(0));
`endif
    p1_MemRead_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    init_check();

    repeat (3) @(negedge clk);
    chk("left_stall_exp", 256'(stall_exp_q.size()), 256'(0));
    chk("left_rd_exp", 256'(rd_exp_q.size()), 256'(0));
    chk("left_mem_exp", 256'(mem_exp_q.size()), 256'(0));
    chk("left_wb_exp", 256'(wb_exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
